// File: rtl/move_input_conditioner_if.sv
// Push-button bundle between the board pins and the move input conditioner.
//   btn_x, btn_y             raw active-high buttons, asynchronous to clk
//   x_increment, y_increment one-cycle registered move pulses
// The conditioner uses the slave modport. The pin or bench side uses master.
interface move_input_conditioner_if;
  logic btn_x;
  logic btn_y;
  logic x_increment;
  logic y_increment;

  modport master (
    output btn_x,
    output btn_y,
    input  x_increment,
    input  y_increment
  );

  modport slave (
    input  btn_x,
    input  btn_y,
    output x_increment,
    output y_increment
  );
endinterface

// File: rtl/move_input_conditioner.sv
// Turns the raw x/y push buttons into single-cycle increment pulses for
// sprite_position. Each channel is processed on its own, in this order:
//   1. a two-flop synchronizer,
//   2. a stability-counter debouncer,
//   3. a press FSM with optional auto-repeat.
// Ports:
//   clk  pixel/system clock; all flops switch on the rising edge
//   rst  asynchronous active-low reset
//   mv   slave modport:
//          btn_x, btn_y             raw button inputs
//          x_increment, y_increment registered pulse outputs
module move_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000,
  parameter int unsigned REPEAT_EN       = 1,
  parameter int unsigned CNT_W           = 25
) (
  input  logic                      clk,
  input  logic                      rst,
  move_input_conditioner_if.slave   mv
);

  localparam int unsigned      N_CH   = 2;
  localparam logic [CNT_W-1:0] D_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] R_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] P_LAST = CNT_W'(REPEAT_PERIOD - 1);
  localparam bit               RPT_ON = (REPEAT_EN != 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  logic [N_CH-1:0] btn_raw;
  logic [N_CH-1:0] inc;

  assign btn_raw        = {mv.btn_y, mv.btn_x};
  assign mv.x_increment = inc[0];
  assign mv.y_increment = inc[1];

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    logic             sync1;
    logic             sync2;
    logic             db;
    logic [CNT_W-1:0] dcnt;
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] rcnt_q;
    logic [CNT_W-1:0] rcnt_d;
    logic             pulse_q;
    logic             pulse_d;

    // Two-flop synchronizer for the asynchronous pin.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sync1 <= 1'b0;
        sync2 <= 1'b0;
      end else begin
        sync1 <= btn_raw[ch];
        sync2 <= sync1;
      end
    end

    // The level is accepted only after D consecutive cycles that disagree with db.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        db   <= 1'b0;
        dcnt <= '0;
      end else if (sync2 == db) begin
        dcnt <= '0;
      end else if (dcnt == D_LAST) begin
        db   <= sync2;
        dcnt <= '0;
      end else begin
        dcnt <= dcnt + CNT_W'(1);
      end
    end

    // Press FSM state, repeat timer and output pulse register.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state_q <= IDLE;
        rcnt_q  <= '0;
        pulse_q <= 1'b0;
      end else begin
        state_q <= state_d;
        rcnt_q  <= rcnt_d;
        pulse_q <= pulse_d;
      end
    end

    // Next-state logic. A release never pulses. With repeat disabled, the timer freezes in HOLD.
    always_comb begin
      state_d = state_q;
      rcnt_d  = rcnt_q;
      pulse_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (db) begin
            pulse_d = 1'b1;
            rcnt_d  = '0;
            state_d = HOLD;
          end
        end
        HOLD: begin
          if (!db) begin
            rcnt_d  = '0;
            state_d = IDLE;
          end else if (RPT_ON) begin
            if (rcnt_q == R_LAST) begin
              pulse_d = 1'b1;
              rcnt_d  = '0;
              state_d = REPEAT;
            end else begin
              rcnt_d = rcnt_q + CNT_W'(1);
            end
          end
        end
        REPEAT: begin
          if (!db) begin
            rcnt_d  = '0;
            state_d = IDLE;
          end else if (rcnt_q == P_LAST) begin
            pulse_d = 1'b1;
            rcnt_d  = '0;
          end else begin
            rcnt_d = rcnt_q + CNT_W'(1);
          end
        end
        default: begin
          rcnt_d  = '0;
          state_d = IDLE;
        end
      endcase
    end

    assign inc[ch] = pulse_q;
  end

endmodule

// File: tb/tb_move_input_conditioner.sv
// Bench for move_input_conditioner with D=4, R=10 and P=3.
// It runs two instances side by side: one with auto-repeat, one without.
// Expected pulses come from per-edge vector tables, a few hand-written
// sequences, and an event-time reference model.
module tb_move_input_conditioner;

  localparam int D = 4;
  localparam int R = 10;
  localparam int P = 3;
  localparam int W = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  move_input_conditioner_if m1 ();
  move_input_conditioner_if m0 ();

  move_input_conditioner #(
    .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(R), .REPEAT_PERIOD(P), .REPEAT_EN(1), .CNT_W(8)
  ) dut_rep (
    .clk(clk), .rst(rst), .mv(m1)
  );

  move_input_conditioner #(
    .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(R), .REPEAT_PERIOD(P), .REPEAT_EN(0), .CNT_W(8)
  ) dut_one (
    .clk(clk), .rst(rst), .mv(m0)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Model channels: 0 = x with repeat, 1 = y with repeat, 2 = x one-shot, 3 = y one-shot.
  bit d1_m  [4];
  bit d2_m  [4];
  bit db_m  [4];
  int run_m [4];
  int rise_m[4];
  int edge_no;

  typedef struct {
    string       name;
    logic [W-1:0] bx;
    logic [W-1:0] by;
    logic [W-1:0] ex1;
    logic [W-1:0] ey1;
    logic [W-1:0] ex0;
    logic [W-1:0] ey0;
    bit          chk1;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string nm, input int k, input logic got, input logic want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s edge %0d: got %b want %b", nm, k, got, want);
  endtask

  function automatic void model_reset();
    for (int c = 0; c < 4; c++) begin
      d1_m[c]   = 1'b0;
      d2_m[c]   = 1'b0;
      db_m[c]   = 1'b0;
      run_m[c]  = 0;
      rise_m[c] = -1000;
    end
    edge_no = 0;
  endfunction

  // Event-time model. Once the accepted level rises at edge e, pulses fall at e+1, then at e+1+R, then every P edges after that.
  function automatic logic [3:0] model_step(input logic [3:0] raw);
    logic [3:0] exp;
    int age;
    bit en;
    edge_no++;
    for (int c = 0; c < 4; c++) begin
      en     = (c < 2);
      age    = edge_no - rise_m[c];
      exp[c] = db_m[c] && ((age == 1) || (en && age >= 1 + R && ((age - 1 - R) % P) == 0));
      // The level the debouncer sees at this edge was sampled two edges earlier.
      if (d2_m[c] != db_m[c]) run_m[c]++;
      else run_m[c] = 0;
      if (run_m[c] == D) begin
        db_m[c]  = d2_m[c];
        run_m[c] = 0;
        if (db_m[c]) rise_m[c] = edge_no;
      end
      d2_m[c] = d1_m[c];
      d1_m[c] = raw[c];
    end
    return exp;
  endfunction

  // Drives one edge, checks all outputs against the model, and optionally against table bits.
  task automatic tick(input logic bx, input logic by, input string nm, input int k,
                      input logic [3:0] want, input logic [3:0] tab_en);
    logic [3:0] exp;
    logic [3:0] got;
    m1.btn_x = bx;
    m1.btn_y = by;
    m0.btn_x = bx;
    m0.btn_y = by;
    @(posedge clk);
    exp = model_step({by, bx, by, bx});
    #1;
    got = {m0.y_increment, m0.x_increment, m1.y_increment, m1.x_increment};
    for (int i = 0; i < 4; i++) begin
      check({nm, "_model"}, k, got[i], exp[i]);
      if (tab_en[i]) check({nm, "_table"}, k, got[i], want[i]);
    end
  endtask

  task automatic do_reset();
    m1.btn_x = 1'b0;
    m1.btn_y = 1'b0;
    m0.btn_x = 1'b0;
    m0.btn_y = 1'b0;
    rst = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
  endtask

  initial begin
    int rem[2];
    logic lvl[2];
    logic [3:0] w;

    vecs[0] = '{"clean", 64'hFF, 64'h0, 64'd1 << 6, 64'h0, 64'd1 << 6, 64'h0, 1'b1};
    vecs[1] = '{"bounce", 64'hFF77, 64'h0, 64'd1 << 14, 64'h0, 64'd1 << 14, 64'h0, 1'b1};
    vecs[2] = '{"hold", 64'hF_FFFF, 64'h0,
                (64'd1 << 6) | (64'd1 << 16) | (64'd1 << 19) | (64'd1 << 22) | (64'd1 << 25),
                64'h0, 64'd1 << 6, 64'h0, 1'b1};
    vecs[3] = '{"simul", 64'hFFF, 64'hFFF, (64'd1 << 6) | (64'd1 << 16),
                (64'd1 << 6) | (64'd1 << 16), 64'd1 << 6, 64'd1 << 6, 1'b1};
    vecs[4] = '{"norepeat", 64'h0, 64'hFFFC_00FF_FFFF_FFFF, 64'h0, 64'h0, 64'h0,
                (64'd1 << 6) | (64'd1 << 56), 1'b0};

    do_reset();
    #1;
    check("reset_x1", 0, m1.x_increment, 1'b0);
    check("reset_y1", 0, m1.y_increment, 1'b0);
    check("reset_x0", 0, m0.x_increment, 1'b0);
    check("reset_y0", 0, m0.y_increment, 1'b0);

    foreach (vecs[v]) begin
      do_reset();
      for (int k = 0; k < W; k++) begin
        tick(vecs[v].bx[k], vecs[v].by[k], vecs[v].name, k,
             {vecs[v].ey0[k], vecs[v].ex0[k], vecs[v].ey1[k], vecs[v].ex1[k]},
             {2'b11, vecs[v].chk1, vecs[v].chk1});
      end
    end

    // Reset while in REPEAT: the pulse must clear without a clock edge, then a fresh press follows.
    do_reset();
    for (int k = 0; k <= 16; k++) tick(1'b1, 1'b0, "rst_hold", k, 4'b0, 4'b0);
    check("rst_pre_pulse", 16, m1.x_increment, 1'b1);
    #1 rst = 1'b0;
    model_reset();
    #1;
    check("rst_async_clear", 16, m1.x_increment, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      check("rst_low_x1", k, m1.x_increment, 1'b0);
      check("rst_low_x0", k, m0.x_increment, 1'b0);
    end
    #1 rst = 1'b1;
    for (int k = 0; k < 10; k++) begin
      w = {1'b0, 1'(k == 6), 1'b0, 1'(k == 6)};
      tick(1'b1, 1'b0, "rst_fresh", k, w, 4'b1111);
    end

    // Random bouncing runs, both channels independent, checked against the model.
    do_reset();
    for (int c = 0; c < 2; c++) begin
      rem[c] = 1;
      lvl[c] = 1'b0;
    end
    for (int n = 0; n < 2000; n++) begin
      for (int c = 0; c < 2; c++) begin
        rem[c]--;
        if (rem[c] == 0) begin
          lvl[c] = ~lvl[c];
          rem[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 60))
                                               : int'($urandom_range(1, 6));
        end
      end
      tick(lvl[0], lvl[1], "random", n, 4'b0, 4'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
